// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with oversampled deframing, a show-ahead receive FIFO,
// sticky overrun/frame-error flags and a level interrupt.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16,
  parameter int INT_THRESH   = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          uart_txd_in,
  input  logic                          rd_en,
  output logic [7:0]                    rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          overrun,
  output logic                          frame_err,
  input  logic                          err_clr,
  output logic                          uart_rx_int,
  output logic                          busy
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int TW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            sync1_q, rxs_q;
  logic            push_s, fe_set_s;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            pop_s, full_s, wr_s, ovr_set_s;
  logic            ovr_q, ovr_d, fe_q, fe_d, int_q;

  // Two-flop synchronizer for the asynchronous serial line, idles high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= uart_txd_in;
      rxs_q   <= sync1_q;
    end
  end

  // Receiver state, bit timer, bit index and shift register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // Deframing: the timer is cleared on every state transition.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + TW'(1);
    bit_d    = bit_q;
    shift_d  = shift_q;
    push_s   = 1'b0;
    fe_set_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rxs_q) begin
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (cnt_q == TW'(HALF - 1)) begin
          cnt_d = '0;
          if (!rxs_q) begin
            state_d = S_DATA;
            bit_d   = 3'd0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (cnt_q == TW'(CLKS_PER_BIT - 1)) begin
          cnt_d   = '0;
          shift_d = {rxs_q, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_STOP: begin
        if (cnt_q == TW'(CLKS_PER_BIT - 1)) begin
          cnt_d = '0;
          if (rxs_q) begin
            push_s  = 1'b1;
            state_d = S_IDLE;
          end else begin
            fe_set_s = 1'b1;
            state_d  = S_BREAK;
          end
        end else begin
          state_d = S_STOP;
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        if (rxs_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_BREAK;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // A full FIFO still accepts a push when the head is popped in the same cycle.
  always_comb begin
    pop_s     = rd_en && (count_q != '0);
    full_s    = (count_q == CW'(FIFO_DEPTH));
    wr_s      = push_s && (!full_s || pop_s);
    ovr_set_s = push_s && full_s && !pop_s;
    case ({wr_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (ovr_set_s) begin
      ovr_d = 1'b1;
    end else if (err_clr) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
    if (fe_set_s) begin
      fe_d = 1'b1;
    end else if (err_clr) begin
      fe_d = 1'b0;
    end else begin
      fe_d = fe_q;
    end
  end

  // FIFO storage, pointers, occupancy, sticky flags and interrupt.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovr_q    <= 1'b0;
      fe_q     <= 1'b0;
      int_q    <= 1'b0;
    end else begin
      if (wr_s) begin
        mem_q[wr_ptr_q] <= shift_q;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
      ovr_q   <= ovr_d;
      fe_q    <= fe_d;
      int_q   <= (count_q >= CW'(INT_THRESH)) || ovr_q || fe_q;
    end
  end

  assign rd_valid    = (count_q != '0);
  assign rd_data     = rd_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign rx_count    = count_q;
  assign overrun     = ovr_q;
  assign frame_err   = fe_q;
  assign uart_rx_int = int_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with CLKS_PER_BIT=8, FIFO_DEPTH=4.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       txd;
  logic       rd_en;
  logic       err_clr;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [2:0] rx_count;
  logic       overrun;
  logic       frame_err;
  logic       uart_rx_int;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int fe_rises = 0;
  int fe_snap  = 0;
  logic fe_prev = 1'b0;

  uart_rx_fifo #(.CLKS_PER_BIT(8), .FIFO_DEPTH(4), .INT_THRESH(1)) dut (
    .clk(clk), .rst(rst), .uart_txd_in(txd), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .rx_count(rx_count),
    .overrun(overrun), .frame_err(frame_err), .err_clr(err_clr),
    .uart_rx_int(uart_rx_int), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    fe_prev <= frame_err;
    if (frame_err && !fe_prev) fe_rises <= fe_rises + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives the first nbits of a {stop, data, start} frame, 8 clocks per bit, from a negedge.
  task automatic send_bits(input logic [7:0] b, input logic stop_b, input int nbits);
    logic [9:0] frame;
    frame = {stop_b, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      txd = frame[i];
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic pop();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  initial begin
    rst = 1'b0; txd = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", rd_valid, 0);
    check("rst_data", rd_data, 0);
    check("rst_count", rx_count, 0);
    check("rst_busy", busy, 0);
    check("rst_int", uart_rx_int, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // 1: single 0xA5, cycle-accurate push timing
    send_bits(8'hA5, 1'b1, 9);
    txd = 1'b1;
    repeat (6) @(negedge clk);
    check("t1_valid_before", rd_valid, 0);
    check("t1_busy_stop", busy, 1);
    @(negedge clk);
    check("t1_valid", rd_valid, 1);
    check("t1_data", rd_data, 8'hA5);
    check("t1_count", rx_count, 1);
    check("t1_fe", frame_err, 0);
    check("t1_int_lag", uart_rx_int, 0);
    @(negedge clk);
    check("t1_int", uart_rx_int, 1);
    pop();
    check("t1_count_pop", rx_count, 0);

    // 2: back-to-back frames
    send_bits(8'h00, 1'b1, 10);
    send_bits(8'hFF, 1'b1, 10);
    send_bits(8'h3C, 1'b1, 10);
    check("t2_count3", rx_count, 3);
    check("t2_d0", rd_data, 8'h00);
    pop();
    check("t2_d1", rd_data, 8'hFF);
    check("t2_count2", rx_count, 2);
    pop();
    check("t2_d2", rd_data, 8'h3C);
    pop();
    check("t2_count0", rx_count, 0);
    check("t2_valid0", rd_valid, 0);

    // 3: short glitch
    txd = 1'b0;
    repeat (3) @(negedge clk);
    txd = 1'b1;
    @(negedge clk);
    check("t3_busy_start", busy, 1);
    repeat (8) @(negedge clk);
    check("t3_busy_idle", busy, 0);
    check("t3_count", rx_count, 0);
    check("t3_ovr", overrun, 0);
    check("t3_fe", frame_err, 0);
    check("t3_int", uart_rx_int, 0);

    // 4a: overflow drops the fifth byte
    send_bits(8'h11, 1'b1, 10);
    send_bits(8'h22, 1'b1, 10);
    send_bits(8'h33, 1'b1, 10);
    send_bits(8'h44, 1'b1, 10);
    send_bits(8'h55, 1'b1, 10);
    check("t4_count", rx_count, 4);
    check("t4_ovr", overrun, 1);
    check("t4_int", uart_rx_int, 1);
    check("t4_d0", rd_data, 8'h11);
    pop();
    check("t4_d1", rd_data, 8'h22);
    pop();
    check("t4_d2", rd_data, 8'h33);
    pop();
    check("t4_d3", rd_data, 8'h44);
    pop();
    check("t4_empty", rd_valid, 0);
    pulse_clr();
    check("t4_ovr_clr", overrun, 0);
    repeat (2) @(negedge clk);
    check("t4_int_clr", uart_rx_int, 0);

    // 4b: pop coincident with push into a full FIFO
    send_bits(8'h61, 1'b1, 10);
    send_bits(8'h62, 1'b1, 10);
    send_bits(8'h63, 1'b1, 10);
    send_bits(8'h64, 1'b1, 10);
    check("t4b_full", rx_count, 4);
    send_bits(8'h65, 1'b1, 9);
    txd = 1'b1;
    repeat (6) @(negedge clk);
    pop();
    check("t4b_ovr", overrun, 0);
    check("t4b_count", rx_count, 4);
    @(negedge clk);
    check("t4b_d1", rd_data, 8'h62);
    pop();
    check("t4b_d2", rd_data, 8'h63);
    pop();
    check("t4b_d3", rd_data, 8'h64);
    pop();
    check("t4b_d4", rd_data, 8'h65);
    pop();
    check("t4b_count0", rx_count, 0);

    // 5: framing error followed by a held-low break
    fe_snap = fe_rises;
    send_bits(8'h55, 1'b0, 10);
    repeat (40) @(negedge clk);
    check("t5_fe", frame_err, 1);
    check("t5_busy_break", busy, 1);
    check("t5_count_break", rx_count, 0);
    txd = 1'b1;
    repeat (16) @(negedge clk);
    check("t5_idle", busy, 0);
    send_bits(8'h12, 1'b1, 10);
    check("t5_count", rx_count, 1);
    check("t5_data", rd_data, 8'h12);
    check("t5_fe_once", fe_rises - fe_snap, 1);
    pulse_clr();
    check("t5_fe_clr", frame_err, 0);
    repeat (2) @(negedge clk);
    check("t5_int_occ", uart_rx_int, 1);
    pop();
    repeat (2) @(negedge clk);
    check("t5_int_off", uart_rx_int, 0);

    // 6: reset mid-frame
    send_bits(8'h99, 1'b1, 10);
    check("t6_pre_count", rx_count, 1);
    send_bits(8'h81, 1'b1, 3);
    check("t6_busy_data", busy, 1);
    rst = 1'b0;
    #1;
    check("t6_busy", busy, 0);
    check("t6_valid", rd_valid, 0);
    check("t6_count", rx_count, 0);
    check("t6_data", rd_data, 0);
    check("t6_int", uart_rx_int, 0);
    check("t6_flags", {overrun, frame_err}, 0);
    txd = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    send_bits(8'h81, 1'b1, 10);
    check("t6_rx_data", rd_data, 8'h81);
    check("t6_rx_count", rx_count, 1);
    check("t6_rx_fe", frame_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
UART receiver for the board serial input `uart_txd_in` (host→FPGA direction), the receive end of the serial link whose transmit pin is `uart_rxd_out`.
- Oversamples the line, deframes 8N1 characters and buffers them in a show-ahead FIFO.
- Raises a level interrupt for the core's interrupt line 6.
- Sits beside the bus UART peripheral; the peripheral's register logic drives `rd_en` and `err_clr`.

Parameters:
CLKS_PER_BIT, 868, clock cycles per bit (100 MHz / 115200); must be ≥4.
FIFO_DEPTH, 16, FIFO entries; power of two, ≥2.
INT_THRESH, 1, FIFO occupancy at or above which `uart_rx_int` asserts; range 1..FIFO_DEPTH.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-low reset
uart_txd_in  input  1  serial data from host, idle high, asynchronous to clk
rd_en  input  1  pop head of FIFO; ignored when empty
rd_data  output  8  head-of-FIFO byte (show-ahead); valid while rd_valid=1
rd_valid  output  1  FIFO non-empty
rx_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
overrun  output  1  sticky: a byte was dropped because the FIFO was full
frame_err  output  1  sticky: a stop bit was sampled low
err_clr  input  1  one-cycle pulse clearing overrun and frame_err
uart_rx_int  output  1  level interrupt
busy  output  1  receiver FSM not in IDLE

Behaviour:
- Reset (rst=0, async assert, sync deassert by the integrator):
  - FSM=IDLE; FIFO empty; rd_valid=0, rd_data=0, rx_count=0.
  - overrun=0, frame_err=0, uart_rx_int=0, busy=0.
  - Synchronizer flops reset to 1.
  - Reset mid-frame discards the partial byte.
- Input synchronization: 2-flop synchronizer; all decisions use the 2nd-stage output `rxs`.
- Bit timer: counter 0..CLKS_PER_BIT-1, restarted on every state entry.
- FSM states and transitions:
  - IDLE: on `rxs`=0 go to START.
  - START: after CLKS_PER_BIT/2 (integer floor) cycles, sample `rxs`.
    - Sample 0: go to DATA, bit index=0.
    - Sample 1: glitch, return to IDLE with no side effects.
  - DATA: sample every CLKS_PER_BIT cycles into the shift register, LSB first. After bit 7, go to STOP.
  - STOP: sample after CLKS_PER_BIT cycles.
    - Sample 1: push byte, return to IDLE.
    - Sample 0: set frame_err, discard byte, go to BREAK.
  - BREAK: remain until `rxs`=1, then IDLE. A held-low line yields exactly one frame_err and no bytes.
- busy=1 in every state except IDLE.
- FIFO push occurs on the stop-sample cycle; rd_valid/rd_data reflect the new byte the next cycle.
- FIFO: circular buffer with wrapping read/write pointers and rx_count as the occupancy counter.
  - Pop on rd_en and rd_valid; rd_data updates the cycle after the pop.
  - Push and pop in the same cycle: both take effect, rx_count unchanged.
  - Push while full with no same-cycle pop: byte dropped, overrun set, FIFO contents unchanged.
  - Push while full with a same-cycle pop: accepted, no overrun.
  - rd_en while empty: no effect, no underflow.
- Sticky flags:
  - err_clr clears both flags next cycle.
  - A set event in the same cycle as err_clr wins; flag stays 1.
- Interrupt: uart_rx_int = registered (rx_count ≥ INT_THRESH) | overrun | frame_err. One cycle after the condition changes.
- Ordering: bytes are delivered in arrival order. No parity; a break produces no byte.

Test Plan:
1. CLKS_PER_BIT=8, send 0xA5 (8N1) → rd_valid rises 1 cycle after the stop sample; rd_data=0xA5; rx_count=1; uart_rx_int=1; frame_err=0.
2. Back-to-back frames 0x00, 0xFF, 0x3C with no idle gap, then 3 rd_en pulses → bytes read in that order; rx_count goes 3→0; rd_valid=0 at the end.
3. Low pulse of 3 cycles (< CLKS_PER_BIT/2) on idle line → FSM returns to IDLE; rx_count=0; busy drops; no flags set.
4. FIFO_DEPTH=4: send 5 bytes with no reads → rx_count=4; overrun=1; reads return the first 4 bytes. Repeat with rd_en coincident with the 5th push → no overrun, 5th byte retained.
5. Frame 0x55 with stop bit forced low, then line held low for 40 cycles, then a valid 0x12 → frame_err=1 once; only 0x12 pushed. err_clr pulse → frame_err=0; uart_rx_int follows FIFO occupancy only.
6. Assert rst=0 mid-DATA of a frame → all outputs return to reset values immediately. After release, the next full frame 0x81 is received correctly.
